// File: rtl/conv_sched.sv
// Window scheduler for the 2D convolution engine: walks a KxK window over the
// pixel RAM, feeds the external MAC, and streams one result per window.
module conv_sched #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         ram_rd_en,
    output logic [$clog2(IMG_W*IMG_H)-1:0]               ram_addr,
    input  logic [7:0]                                   ram_rdata,
    output logic                                         mac_en,
    output logic                                         mac_clr,
    output logic [7:0]                                   mac_pix,
    output logic [3:0]                                   mac_kidx,
    input  logic [15:0]                                  mac_acc,
    output logic                                         out_valid,
    output logic [15:0]                                  out_data,
    output logic [$clog2((IMG_W-K+1)*(IMG_H-K+1))-1:0]   out_idx,
    input  logic                                         out_ready
);

    // state    | meaning
    // IDLE     | waiting for start
    // FETCH    | one RAM read per kernel tap, K*K cycles
    // DRAIN    | last read data reaches the MAC
    // WAIT_ACC | accumulator settles, result captured
    // OUTPUT   | result offered downstream until accepted
    // DONE     | one-cycle completion pulse
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_WAIT_ACC = 3'd3;
    localparam logic [2:0] S_OUTPUT   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int NOUT  = OUT_W * OUT_H;
    localparam int KK    = K * K;
    localparam int AW    = $clog2(IMG_W * IMG_H);
    localparam int OW    = $clog2(NOUT);

    logic [2:0]    state;
    logic [3:0]    k;
    logic [3:0]    kc;
    logic [AW-1:0] tap_off;
    logic [AW-1:0] win_base;
    logic [OW-1:0] ocol;
    logic [OW-1:0] out_cnt;

    // Addresses are built incrementally (window base + tap offset) so no
    // multiplier or divider is needed on the read path.
    assign ram_rd_en = (state == S_FETCH);
    assign ram_addr  = (state == S_FETCH) ? (win_base + tap_off) : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign out_valid = (state == S_OUTPUT);
    assign mac_pix   = mac_en ? ram_rdata : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            mac_kidx <= 4'd0;
        end else begin
            mac_en   <= (state == S_FETCH);
            mac_clr  <= (state == S_FETCH) && (k == 4'd0);
            mac_kidx <= (state == S_FETCH) ? k : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k        <= 4'd0;
            kc       <= 4'd0;
            tap_off  <= '0;
            win_base <= '0;
            ocol     <= '0;
            out_cnt  <= '0;
            out_data <= 16'd0;
            out_idx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        k        <= 4'd0;
                        kc       <= 4'd0;
                        tap_off  <= '0;
                        win_base <= '0;
                        ocol     <= '0;
                        out_cnt  <= '0;
                    end
                end
                S_FETCH: begin
                    if (k == 4'(KK - 1)) begin
                        state   <= S_DRAIN;
                        k       <= 4'd0;
                        kc      <= 4'd0;
                        tap_off <= '0;
                    end else begin
                        k <= k + 4'd1;
                        if (kc == 4'(K - 1)) begin
                            kc      <= 4'd0;
                            tap_off <= tap_off + AW'(IMG_W - K + 1);
                        end else begin
                            kc      <= kc + 4'd1;
                            tap_off <= tap_off + AW'(1);
                        end
                    end
                end
                S_DRAIN: state <= S_WAIT_ACC;
                S_WAIT_ACC: begin
                    out_data <= mac_acc;
                    out_idx  <= out_cnt;
                    state    <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        if (out_cnt == OW'(NOUT - 1)) begin
                            state <= S_DONE;
                        end else begin
                            state   <= S_FETCH;
                            out_cnt <= out_cnt + OW'(1);
                            // Wrapping to the next row skips the K-1 columns
                            // a window cannot start in.
                            if (ocol == OW'(OUT_W - 1)) begin
                                ocol     <= '0;
                                win_base <= win_base + AW'(K);
                            end else begin
                                ocol     <= ocol + OW'(1);
                                win_base <= win_base + AW'(1);
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencing controller for the 2D convolution engine. It walks a K×K window in raster order over an IMG_H×IMG_W 8-bit image held in the pixel RAM. For each window it issues K×K RAM reads and drives the external multiply-accumulate datapath with pixel/kernel-index pairs. It then captures the 16-bit accumulated result and hands it downstream over a valid/ready handshake. It sits between the pixel RAM, the MAC unit and the output stream.

## Interface
- IMG_W, 8, image width in pixels
- IMG_H, 8, image height in pixels
- K, 3, kernel size; OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1 (6×6 = 36 results at defaults)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from the cycle after accepted start until DONE
- done  out  1  one-cycle pulse after the last result transfers
- ram_rd_en  out  1  RAM read strobe
- ram_addr  out  clog2(IMG_W*IMG_H) (6)  read address, row*IMG_W+col
- ram_rdata  in  8  read data, valid the cycle after ram_rd_en
- mac_en  out  1  MAC operand valid
- mac_clr  out  1  with mac_en: MAC loads product instead of accumulating
- mac_pix  out  8  pixel operand
- mac_kidx  out  4  kernel coefficient index 0..K*K-1, row-major
- mac_acc  in  16  MAC accumulator, valid the cycle after the last mac_en
- out_valid  out  1  result available
- out_data  out  16  convolution result
- out_idx  out  clog2(OUT_W*OUT_H) (6)  result index, orow*OUT_W+ocol
- out_ready  in  1  downstream accepts when high with out_valid

## Operation
- Reset: every output is 0, state is IDLE, and window counters orow/ocol are 0. Reset takes effect immediately and asynchronously. A reset mid-frame aborts the frame with no done pulse.
- States:
  - IDLE: start=1 leads to FETCH, with orow=ocol=0 and k=0. start is ignored in all other states.
  - FETCH (K*K cycles, k=0..8): ram_rd_en=1 and ram_addr=(orow+k/K)*IMG_W+ocol+k%K. After k=8 the state moves to DRAIN.
  - DRAIN (1 cycle): no read is issued; the last mac_en is issued.
  - WAIT_ACC (1 cycle): out_data<=mac_acc and out_idx<=orow*OUT_W+ocol are captured at the end of the cycle.
  - OUTPUT: out_valid=1. out_data and out_idx are held stable until a cycle with out_ready=1.
    - On transfer, if the index is not the last (OUT_W*OUT_H-1): advance ocol; when ocol=OUT_W-1, wrap ocol to 0 and increment orow. Then return to FETCH.
    - On the last index, go to DONE.
  - DONE (1 cycle): done=1, then IDLE.
- MAC pipeline: mac_en is asserted in the cycle after each FETCH read, with mac_pix=ram_rdata and mac_kidx=k of that read. mac_clr=1 only with kidx=0.
  - No MAC or RAM activity occurs outside FETCH/DRAIN.
  - mac_en and mac_clr are 0 in IDLE, WAIT_ACC, OUTPUT and DONE.
- busy=1 in every state except IDLE.
- No reads are issued while OUTPUT is stalled. Backpressure never drops or reorders results.
- Results come out strictly in raster order, indices 0..35, each exactly once.

## Timing
- start sampled at edge 0:
  - FETCH covers cycles 1–9.
  - DRAIN is cycle 10.
  - WAIT_ACC is cycle 11.
  - The first out_valid is in cycle 12.
- With out_ready held at 1, each window takes 12 cycles. Result n has out_valid in cycle 12n+12. The last result is in cycle 432, and done is in cycle 433.
- Each stall cycle with out_ready=0 delays every later event by exactly 1 cycle.
- If start=1 and reset deassert in the same cycle, start is still sampled normally at the next edge.
- start held high across frames does not retrigger: the next frame begins only from IDLE, so start must still be high on the cycle after done.

## Test plan
- Ramp image, pixel[a]=a, out_ready=1, MAC model with all kernel weights 1 (sum of 9) -> results 9*(orow*8+ocol+9): out_idx 0 = 81, idx 7 = 162, idx 35 = 486. done in cycle 433 with exactly 36 transfers.
- Address check, window idx 7 (orow 1, ocol 1) -> ram_addr sequence 9,10,11,17,18,19,25,26,27 with mac_kidx 0..8 lagging by one cycle. mac_clr only alongside kidx 0.
- out_ready low for 5 cycles at idx 7 -> out_valid stays high, out_data=162 and out_idx=7 stay stable, ram_rd_en=0 throughout, done moves to cycle 438.
- start pulsed in cycles 5 and 200 during a frame -> no effect. Exactly 36 results and one done pulse.
- rst_n low in cycle 6 (mid-FETCH) -> all outputs 0 at once and no done. A new start then yields the full 36-result sequence from idx 0 with the nominal timing.
- Random out_ready (50%) over a random image -> results match a reference convolution bit-exactly, in order idx 0..35.
